// File: rtl/dial_emu.sv
// ============================================================================
// dial_emu : joystick up/down to quadrature rotary-dial emulator, N channels
// Revision : 1.0
// ============================================================================
`default_nettype none

module dial_emu #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic [DIV_W-1:0]        rate,
  input  logic [CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]     invert,
  input  logic [CHANNELS-1:0]     up,
  input  logic [CHANNELS-1:0]     down,
  output logic [2*CHANNELS-1:0]   dial_out,
  output logic [CHANNELS-1:0]     step_pulse,
  output logic [8*CHANNELS-1:0]   position
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } dir_e;

  // Forward Gray order 11 -> 10 -> 00 -> 01 -> 11; reverse walks it backwards.
  function automatic logic [1:0] phase_fwd(input logic [1:0] p);
    case (p)
      2'b11:   phase_fwd = 2'b10;
      2'b10:   phase_fwd = 2'b00;
      2'b00:   phase_fwd = 2'b01;
      default: phase_fwd = 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] phase_rev(input logic [1:0] p);
    case (p)
      2'b11:   phase_rev = 2'b01;
      2'b01:   phase_rev = 2'b00;
      2'b00:   phase_rev = 2'b10;
      default: phase_rev = 2'b11;
    endcase
  endfunction

  logic [DIV_W-1:0] rate_m1;
  assign rate_m1 = (rate == '0) ? '0 : rate - DIV_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dir_e             state_q, state_d, want;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       pos_q, pos_d;
    logic             u_eff, d_eff, step_fwd, step_rev;

    always_comb begin
      u_eff    = invert[i] ? down[i] : up[i];
      d_eff    = invert[i] ? up[i]   : down[i];
      want     = ST_IDLE;
      if (u_eff && !d_eff)      want = ST_FWD;
      else if (d_eff && !u_eff) want = ST_REV;

      state_d  = state_q;
      cnt_d    = cnt_q;
      step_fwd = 1'b0;
      step_rev = 1'b0;
      if (!mode[i] || want == ST_IDLE) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (want != state_q) begin
        // Leaving idle or reversing steps at once, regardless of ce.
        state_d  = want;
        cnt_d    = '0;
        step_fwd = (want == ST_FWD);
        step_rev = (want == ST_REV);
      end else if (ce) begin
        if (cnt_q >= rate_m1) begin
          cnt_d    = '0;
          step_fwd = (state_q == ST_FWD);
          step_rev = (state_q == ST_REV);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      phase_d = phase_q;
      pos_d   = pos_q;
      if (!mode[i]) begin
        phase_d = 2'b11;
      end else if (step_fwd) begin
        phase_d = phase_fwd(phase_q);
        pos_d   = pos_q + 8'd1;
      end else if (step_rev) begin
        phase_d = phase_rev(phase_q);
        pos_d   = pos_q - 8'd1;
      end
      pulse_d = step_fwd | step_rev;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        phase_q <= 2'b11;
        pulse_q <= 1'b0;
        pos_q   <= 8'd0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
        pulse_q <= pulse_d;
        pos_q   <= pos_d;
      end
    end

    assign dial_out[2*i +: 2] = phase_q;
    assign step_pulse[i]      = pulse_q;
    assign position[8*i +: 8] = pos_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dial_emu.sv
// Testbench for dial_emu: directed vector table, corner sequences, random run vs model.
`default_nettype none

module tb_dial_emu;
  localparam int CH = 2;
  localparam int DW = 16;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic            ce      = 1'b0;
  logic [DW-1:0]   rate    = '0;
  logic [CH-1:0]   mode    = '0;
  logic [CH-1:0]   invert  = '0;
  logic [CH-1:0]   up      = '0;
  logic [CH-1:0]   down    = '0;
  logic [2*CH-1:0] dial_out;
  logic [CH-1:0]   step_pulse;
  logic [8*CH-1:0] position;

  dial_emu #(.CHANNELS(CH), .DIV_W(DW)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce         (ce),
    .rate       (rate),
    .mode       (mode),
    .invert     (invert),
    .up         (up),
    .down       (down),
    .dial_out   (dial_out),
    .step_pulse (step_pulse),
    .position   (position)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: direction as -1/0/+1, phase as an index into the Gray cycle.
  int          m_dir [CH];
  int          m_cnt [CH];
  int          m_ph  [CH];
  int          m_pos [CH];
  logic [CH-1:0] m_pulse;

  function automatic logic [1:0] gray_of(input int k);
    case (k & 3)
      0:       gray_of = 2'b11;
      1:       gray_of = 2'b10;
      2:       gray_of = 2'b00;
      default: gray_of = 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_dir[c] = 0; m_cnt[c] = 0; m_ph[c] = 0; m_pos[c] = 0;
    end
    m_pulse = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int u, d, want, stp, per;
      u    = invert[c] ? int'(down[c]) : int'(up[c]);
      d    = invert[c] ? int'(up[c])   : int'(down[c]);
      want = u - d;
      stp  = 0;
      per  = (rate == 0) ? 1 : int'(rate);
      if (!mode[c]) begin
        m_dir[c] = 0; m_cnt[c] = 0; m_ph[c] = 0;
      end else if (want == 0) begin
        m_dir[c] = 0; m_cnt[c] = 0;
      end else if (want != m_dir[c]) begin
        m_dir[c] = want; m_cnt[c] = 0; stp = want;
      end else if (ce) begin
        if (m_cnt[c] >= per - 1) begin
          m_cnt[c] = 0; stp = want;
        end else begin
          m_cnt[c]++;
        end
      end
      m_ph[c]    = (m_ph[c] + stp + 4) % 4;
      m_pos[c]   = (m_pos[c] + stp + 256) % 256;
      m_pulse[c] = (stp != 0);
    end
  endtask

  function automatic logic [2*CH-1:0] exp_dial();
    logic [2*CH-1:0] v;
    for (int c = 0; c < CH; c++) v[2*c +: 2] = gray_of(m_ph[c]);
    return v;
  endfunction

  function automatic logic [8*CH-1:0] exp_pos();
    logic [8*CH-1:0] v;
    for (int c = 0; c < CH; c++) v[8*c +: 8] = 8'(m_pos[c]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    check("model_dial",  32'(dial_out),   32'(exp_dial()));
    check("model_pulse", 32'(step_pulse), 32'(m_pulse));
    check("model_pos",   32'(position),   32'(exp_pos()));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [CH-1:0]   mode, invert, up, down;
    logic            ce;
    logic [DW-1:0]   rate;
    logic [2*CH-1:0] dial;
    logic [CH-1:0]   pulse;
    logic [8*CH-1:0] pos;
  } vec_t;

  function automatic vec_t mk(input logic [CH-1:0] m, input logic [CH-1:0] inv,
                              input logic [CH-1:0] u, input logic [CH-1:0] d,
                              input logic c, input logic [DW-1:0] r,
                              input logic [2*CH-1:0] dl, input logic [CH-1:0] p,
                              input logic [8*CH-1:0] ps);
    vec_t v;
    v.mode = m; v.invert = inv; v.up = u; v.down = d; v.ce = c; v.rate = r;
    v.dial = dl; v.pulse = p; v.pos = ps;
    return v;
  endfunction

  vec_t vecs [15];
  int   pulse_at [$];

  initial begin
    vecs[0]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b1110, 2'b01, 16'h0001);
    vecs[1]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b1110, 2'b00, 16'h0001);
    vecs[2]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b1110, 2'b00, 16'h0001);
    vecs[3]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b1110, 2'b00, 16'h0001);
    vecs[4]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b1100, 2'b01, 16'h0002);
    vecs[5]  = mk(2'b11, 2'b00, 2'b11, 2'b10, 1'b1, 16'd4, 4'b1100, 2'b00, 16'h0002);
    vecs[6]  = mk(2'b11, 2'b00, 2'b01, 2'b10, 1'b1, 16'd4, 4'b0100, 2'b10, 16'hFF02);
    vecs[7]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b0100, 2'b00, 16'hFF02);
    vecs[8]  = mk(2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 16'd4, 4'b0101, 2'b01, 16'hFF03);
    vecs[9]  = mk(2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 16'd4, 4'b0100, 2'b01, 16'hFF02);
    vecs[10] = mk(2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 16'd4, 4'b0111, 2'b00, 16'hFF02);
    vecs[11] = mk(2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 16'd0, 4'b0111, 2'b00, 16'hFF02);
    vecs[12] = mk(2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 16'd0, 4'b1111, 2'b10, 16'h0002);
    vecs[13] = mk(2'b11, 2'b00, 2'b10, 2'b00, 1'b1, 16'd0, 4'b1011, 2'b10, 16'h0102);
    vecs[14] = mk(2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 16'd0, 4'b1011, 2'b00, 16'h0102);

    // Reset state
    do_reset();
    check("reset_dial",  32'(dial_out),   32'hF);
    check("reset_pulse", 32'(step_pulse), 32'h0);
    check("reset_pos",   32'(position),   32'h0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      mode = vecs[i].mode; invert = vecs[i].invert; up = vecs[i].up;
      down = vecs[i].down; ce = vecs[i].ce; rate = vecs[i].rate;
      tick();
      check($sformatf("vec%0d_dial", i),  32'(dial_out),   32'(vecs[i].dial));
      check($sformatf("vec%0d_pulse", i), 32'(step_pulse), 32'(vecs[i].pulse));
      check($sformatf("vec%0d_pos", i),   32'(position),   32'(vecs[i].pos));
    end

    // Reversal mid-count at rate 8: immediate reverse step, then 8 cycles later
    do_reset();
    mode = 2'b11; invert = 2'b00; ce = 1'b1; rate = 16'd8; up = 2'b01; down = 2'b00;
    tick();
    check("rev_first_step", 32'(step_pulse[0]), 32'h1);
    repeat (5) tick();
    up = 2'b00; down = 2'b01;
    tick();
    check("rev_immediate", 32'(step_pulse[0]), 32'h1);
    check("rev_phase", 32'(dial_out[1:0]), 32'(2'b11));
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("rev_quiet", 32'(step_pulse[0]), 32'h0);
    end
    tick();
    check("rev_period8", 32'(step_pulse[0]), 32'h1);

    // Mode drop at position 7: channel 0 parks, channel 1 keeps going
    do_reset();
    mode = 2'b11; rate = 16'd1; up = 2'b11; down = 2'b00; ce = 1'b1;
    repeat (7) tick();
    check("mode_pos7", 32'(position[7:0]), 32'd7);
    mode = 2'b10;
    tick();
    check("mode_dial11", 32'(dial_out[1:0]), 32'(2'b11));
    check("mode_ch1_step", 32'(step_pulse[1]), 32'h1);
    repeat (3) begin
      tick();
      check("mode_no_pulse", 32'(step_pulse[0]), 32'h0);
      check("mode_pos_held", 32'(position[7:0]), 32'd7);
    end

    // ce 1-in-3 with rate 2: steps every 6 clocks, then asynchronous reset
    do_reset();
    mode = 2'b11; rate = 16'd2; up = 2'b01; down = 2'b00;
    pulse_at.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      ce = (cyc % 3 == 0);
      tick();
      if (step_pulse[0]) pulse_at.push_back(cyc);
    end
    check("ce_step_count", 32'(pulse_at.size()), 32'd5);
    for (int k = 1; k < pulse_at.size(); k++)
      check("ce_step_gap", 32'(pulse_at[k] - pulse_at[k-1]), 32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_dial",  32'(dial_out),   32'hF);
    check("async_pos",   32'(position),   32'h0);
    check("async_pulse", 32'(step_pulse), 32'h0);
    model_reset();
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;

    // Randomized run against the reference model
    mode = 2'b11; rate = 16'd3; up = '0; down = '0; invert = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) up   = CH'($urandom);
      if ($urandom_range(0, 5) == 0) down = CH'($urandom);
      if ($urandom_range(0, 40) == 0) invert = CH'($urandom);
      if ($urandom_range(0, 60) == 0) rate = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 30) == 0)
        for (int c = 0; c < CH; c++) mode[c] = ($urandom_range(0, 4) != 0);
      ce = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dial_emu.md
Name: dial_emu

Overview:
- Multi-channel joystick-to-rotary-dial emulator.
- Sits between the hps_io joystick decode and the game core's player input ports.
- Converts per-player up/down digital controls into 2-bit quadrature dial phases at a programmable step rate, and tracks an 8-bit position per channel.
- Generalises the fixed 2-player, single-step dial hack to N channels, with runtime rate, direction invert and per-channel spinner/joystick mode.

Parameters:
- CHANNELS, 2, number of independent dial channels.
- DIV_W, 16, width of the step-rate divider and per-channel repeat counters.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; counters advance only when ce=1.
- rate  in  DIV_W  step period in ce-qualified cycles; 0 is treated as 1.
- mode  in  CHANNELS  per channel: 1=spinner (emulate dial), 0=Kbd/Joy (dial idle).
- invert  in  CHANNELS  per channel: 1 swaps the meaning of up/down.
- up  in  CHANNELS  per-channel up request, active high.
- down  in  CHANNELS  per-channel down request, active high.
- dial_out  out  2*CHANNELS  quadrature phases; channel i occupies bits [2i+1:2i].
- step_pulse  out  CHANNELS  one-cycle strobe on each dial step.
- position  out  8*CHANNELS  per-channel wrapping step count; channel i occupies bits [8i+7:8i].

Behaviour:
- Reset (async, reset_n=0):
  - dial_out = all 2'b11.
  - step_pulse = 0, position = 0, repeat counters = 0, direction state = IDLE.
  - Release is synchronous to clk_sys.
- Effective direction per channel, computed from u=up^..., with invert applied first (swap up/down):
  - u=1, d=0 -> FWD.
  - u=0, d=1 -> REV.
  - u=d -> IDLE, including both pressed.
- Per-channel state machine, states IDLE, FWD, REV:
  - IDLE -> FWD/REV: first step on the cycle after the request is sampled, independent of ce. Repeat counter cleared.
  - FWD <-> REV (reversal): immediate step in the new direction on the next cycle. Repeat counter cleared.
  - Any -> IDLE: no step. Phase holds at its current value. Counter cleared.
- Repeat stepping in FWD or REV:
  - On each ce=1 cycle the counter increments.
  - When counter == max(rate,1)-1 and ce=1: step, counter -> 0.
  - Step period is therefore max(rate,1) ce-cycles after the initial step.
- Phase sequence:
  - FWD: 11 -> 10 -> 00 -> 01 -> 11 (Gray; exactly one bit changes per step).
  - REV: the reverse order.
- Each step:
  - step_pulse[i]=1 for exactly one clk_sys cycle.
  - position +1 (FWD) or -1 (REV), modulo 256. 255+1 = 0; 0-1 = 255.
- mode[i]=0:
  - dial_out[i] forced to 11, state forced IDLE, counter cleared, no steps.
  - position is held, not cleared.
  - Changing mode 0 -> 1 with a direction already held counts as an IDLE -> active transition: immediate step.
- rate change mid-run:
  - Takes effect at the next comparison.
  - If the counter is already >= the new rate-1, step on the next ce=1 cycle and reset the counter to 0.
- Channels are fully independent. Simultaneous steps on several channels are all honoured in the same cycle.
- Outputs are registered: dial_out, step_pulse and position update together, one cycle after the triggering event.

Test Plan:
1. Reset, then mode=1, rate=4, ce=1, up[0] held for 10 cycles.
   -> Step at cycle 1, then every 4 cycles (3 steps total).
   -> dial_out[1:0] goes 11 -> 10 -> 00 -> 01.
   -> position[7:0] = 3; exactly 3 step_pulse[0] strobes.
2. Channel 0 at position 0 (after reset), down held, invert=0, rate=1.
   -> position counts 255, 254, ... one per cycle.
   -> Phase follows the reverse sequence starting 11 -> 01.
   -> Same stimulus with invert=1 gives +1 per cycle instead.
3. up and down both asserted on channel 1.
   -> No steps, phase held, position unchanged.
   -> Releasing down yields an immediate forward step next cycle.
4. FWD stepping at rate=8; at counter=5 switch to down only.
   -> Reverse step on the next cycle, counter restarts.
   -> Next reverse step exactly 8 ce-cycles later.
5. mode[0] dropped to 0 mid-stepping with position=7.
   -> dial_out[1:0]=11 next cycle, no further step_pulse, position stays 7.
   -> Channel 1 keeps stepping unaffected.
6. ce toggling 1-in-3 with rate=2.
   -> Repeat steps every 2 ce pulses (6 clk_sys cycles).
   -> Assert reset_n=0 mid-run: all outputs reset asynchronously in the same cycle (dial_out=11, position=0).
